keypad_scan: RTL and testbench

- Input-side counterpart of the 8-digit 7-segment scan driver: scans a 4x4 active-low key matrix instead of 8 active-low digit anodes.
- Drives one column low at a time and samples the row lines.
- Debounces over whole scan frames and emits a 4-bit key code with a one-cycle valid strobe.
- Feeds the clock's time-set logic in the same 1 MHz domain as the display driver.

---
 rtl/keypad_scan_if.sv | 12 +
 rtl/keypad_scan.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Key matrix bundle between the keypad scanner and the time-set logic.
// The scanner drives COL and the key results; the matrix side drives ROW.
interface keypad_scan_if;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] oKey;
  logic       oValid;
  logic       oHeld;

  modport master (input ROW, output COL, output oKey, output oValid, output oHeld);
  modport slave  (output ROW, input COL, input oKey, input oValid, input oHeld);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low key matrix scanner: one-cold column drive, synchronized row sampling,
// frame classification and a press/release debounce FSM with a one-cycle valid strobe.
module keypad_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 5
) (
  input  logic          CP_1MHz,
  input  logic          CR,
  keypad_scan_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEB_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  // Frame bit index is col*4+row; the key code swaps the fields to row*4+col.
  function automatic logic [3:0] key_code(input logic [15:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) c = {i[1:0], i[3:2]};
      else      c = c;
    end
    return c;
  endfunction

  logic [3:0]       row_meta_r, row_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_idx_r;
  logic [3:0]       col_r;
  logic [15:0]      frame_r;
  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s, cnt_inc_s;
  logic [3:0]       cand_r, cand_nx_s, key_r, key_nx_s;
  logic             valid_r, valid_nx_s, held_r, held_nx_s;
  logic             sample_s, frame_end_s, is_none_s, is_single_s;
  logic [15:0]      frame_full_s;
  logic [4:0]       nbits_s;
  logic [3:0]       code_s;

  assign sample_s    = (div_r == DIV_W'(SCAN_DIV - 1));
  assign frame_end_s = sample_s && (col_idx_r == 2'd3);
  assign nbits_s     = popcnt16(frame_full_s);
  assign code_s      = key_code(frame_full_s);
  assign is_none_s   = (nbits_s == 5'd0);
  assign is_single_s = (nbits_s == 5'd1);
  assign cnt_inc_s   = (cnt_r >= CNT_W'(DEB_FRAMES)) ? cnt_r : cnt_r + CNT_W'(1);

  // Completed frame: stored columns 0..2 plus the column 3 sample taken this cycle.
  always_comb begin
    frame_full_s         = frame_r;
    frame_full_s[15:12]  = ~row_sync_r;
  end

  // Row synchronizer, column divider/decoder and per-column frame capture.
  always_ff @(posedge CP_1MHz) begin
    if (CR) begin
      row_meta_r <= 4'd0;
      row_sync_r <= 4'd0;
      div_r      <= '0;
      col_idx_r  <= 2'd0;
      col_r      <= 4'b1110;
      frame_r    <= 16'd0;
    end else begin
      row_meta_r <= kp.ROW;
      row_sync_r <= row_meta_r;
      if (sample_s) begin
        div_r     <= '0;
        col_idx_r <= col_idx_r + 2'd1;
        col_r     <= ~(4'b0001 << (col_idx_r + 2'd1));
        if (col_idx_r == 2'd3) frame_r <= 16'd0;
        else                   frame_r[{col_idx_r, 2'b00} +: 4] <= ~row_sync_r;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end
  end

  // Debounce next-state logic, evaluated only on frame-end cycles.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    cand_nx_s  = cand_r;
    key_nx_s   = key_r;
    held_nx_s  = held_r;
    valid_nx_s = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (is_single_s) begin
            cand_nx_s  = code_s;
            cnt_nx_s   = CNT_W'(1);
            state_nx_s = PRESS_CHK;
          end else begin
            state_nx_s = IDLE;
          end
        end
        PRESS_CHK: begin
          if (is_single_s && (code_s == cand_r)) begin
            cnt_nx_s = cnt_inc_s;
            if (cnt_inc_s == CNT_W'(DEB_FRAMES)) begin
              key_nx_s   = cand_r;
              valid_nx_s = 1'b1;
              held_nx_s  = 1'b1;
              state_nx_s = HELD;
            end else begin
              state_nx_s = PRESS_CHK;
            end
          end else if (is_single_s) begin
            cand_nx_s = code_s;
            cnt_nx_s  = CNT_W'(1);
          end else begin
            cnt_nx_s   = '0;
            state_nx_s = IDLE;
          end
        end
        HELD: begin
          if (is_none_s) begin
            cnt_nx_s   = CNT_W'(1);
            state_nx_s = REL_CHK;
          end else begin
            state_nx_s = HELD;
          end
        end
        REL_CHK: begin
          if (is_none_s) begin
            cnt_nx_s = cnt_inc_s;
            if (cnt_inc_s == CNT_W'(DEB_FRAMES)) begin
              held_nx_s  = 1'b0;
              state_nx_s = IDLE;
            end else begin
              state_nx_s = REL_CHK;
            end
          end else begin
            cnt_nx_s   = '0;
            state_nx_s = HELD;
          end
        end
        default: begin
          cnt_nx_s   = '0;
          held_nx_s  = 1'b0;
          state_nx_s = IDLE;
        end
      endcase
    end else begin
      valid_nx_s = 1'b0;
    end
  end

  // Debounce state and registered key outputs.
  always_ff @(posedge CP_1MHz) begin
    if (CR) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      cand_r  <= 4'd0;
      key_r   <= 4'd0;
      valid_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      cand_r  <= cand_nx_s;
      key_r   <= key_nx_s;
      valid_r <= valid_nx_s;
      held_r  <= held_nx_s;
    end
  end

  assign kp.COL    = col_r;
  assign kp.oKey   = key_r;
  assign kp.oValid = valid_r;
  assign kp.oHeld  = held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEB_FRAMES=3): a key-matrix model
// driven from a key mask, table-driven frame steps and hand-written reset sequences.
`timescale 1ns/1ps
module tb_keypad_scan;

  logic        clk;
  logic        cr;
  logic [15:0] mask;
  int          n_checks;
  int          n_pass;
  int          vcnt;
  logic        prev_valid;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(4), .DEB_FRAMES(3)) dut (
    .CP_1MHz(clk),
    .CR     (cr),
    .kp     (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: key (r,c) pulls ROW[r] low while column c is driven low.
  always_comb begin
    kif.ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !kif.COL[c]) kif.ROW[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (kif.oValid) begin
      vcnt++;
      chk("valid_one_cycle", int'(prev_valid), 0);
    end
    prev_valid = kif.oValid;
  end

  typedef struct {
    logic [15:0] m;
    int          frames;
    int          exp_valid;
    logic        exp_held;
    logic [3:0]  exp_key;
  } step_t;

  localparam logic [15:0] K0 = 16'h0001;
  localparam logic [15:0] K3 = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K9 = 16'h0200;

  step_t tbl [22];

  task automatic run_step(input logic [15:0] m, input int frames, input int exp_valid,
                          input logic exp_held, input logic [3:0] exp_key, input string tag);
    int v0;
    v0   = vcnt;
    mask = m;
    repeat (frames * 16) @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_valid_count"}, vcnt - v0, exp_valid);
    chk({tag, "_held"}, int'(kif.oHeld), int'(exp_held));
    chk({tag, "_key"}, int'(kif.oKey), int'(exp_key));
  endtask

  task automatic do_reset(input string tag);
    cr = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_col"}, int'(kif.COL), 14);
    chk({tag, "_key"}, int'(kif.oKey), 0);
    chk({tag, "_valid"}, int'(kif.oValid), 0);
    chk({tag, "_held"}, int'(kif.oHeld), 0);
    cr = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_col;
    n_checks   = 0;
    n_pass     = 0;
    vcnt       = 0;
    prev_valid = 1'b0;
    mask       = 16'h0000;
    cr         = 1'b1;

    tbl[0]  = '{16'h0000, 13, 0, 1'b0, 4'd0};
    tbl[1]  = '{K9,        2, 0, 1'b0, 4'd0};
    tbl[2]  = '{K9,        1, 1, 1'b1, 4'd9};
    tbl[3]  = '{K9,        2, 0, 1'b1, 4'd9};
    tbl[4]  = '{16'h0000,  2, 0, 1'b1, 4'd9};
    tbl[5]  = '{16'h0000,  1, 0, 1'b0, 4'd9};
    tbl[6]  = '{K9,        2, 0, 1'b0, 4'd9};
    tbl[7]  = '{16'h0000,  1, 0, 1'b0, 4'd9};
    tbl[8]  = '{K9,        2, 0, 1'b0, 4'd9};
    tbl[9]  = '{16'h0000,  2, 0, 1'b0, 4'd9};
    tbl[10] = '{K0 | K5,   6, 0, 1'b0, 4'd9};
    tbl[11] = '{K5,        2, 0, 1'b0, 4'd9};
    tbl[12] = '{K5,        1, 1, 1'b1, 4'd5};
    tbl[13] = '{16'h0000,  3, 0, 1'b0, 4'd5};
    tbl[14] = '{K9,        3, 1, 1'b1, 4'd9};
    tbl[15] = '{K9 | K3,   4, 0, 1'b1, 4'd9};
    tbl[16] = '{16'h0000,  2, 0, 1'b1, 4'd9};
    tbl[17] = '{16'h0000,  1, 0, 1'b0, 4'd9};
    tbl[18] = '{K9,        3, 1, 1'b1, 4'd9};
    tbl[19] = '{16'h0000,  2, 0, 1'b1, 4'd9};
    tbl[20] = '{K9,        1, 0, 1'b1, 4'd9};
    tbl[21] = '{16'h0000,  3, 0, 1'b0, 4'd9};

    repeat (2) @(posedge clk);
    do_reset("por");

    for (int k = 0; k < 32; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      chk("col_scan", int'(kif.COL), int'(exp_col));
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 22; i++)
      run_step(tbl[i].m, tbl[i].frames, tbl[i].exp_valid, tbl[i].exp_held,
               tbl[i].exp_key, $sformatf("row%0d", i));

    // Reset during PRESS_CHK, then a clean press is still accepted.
    do_reset("idle_rst");
    run_step(K9, 2, 0, 1'b0, 4'd0, "pre_press");
    do_reset("press_rst");
    run_step(K9, 2, 0, 1'b0, 4'd0, "after_press_rst");
    run_step(16'h0000, 1, 0, 1'b0, 4'd0, "gap1");
    run_step(K9, 3, 1, 1'b1, 4'd9, "press9");
    // Reset during HELD drops oHeld and oKey without a strobe.
    do_reset("held_rst");
    run_step(K9, 2, 0, 1'b0, 4'd0, "after_held_rst");
    run_step(16'h0000, 1, 0, 1'b0, 4'd0, "gap2");
    run_step(K3, 3, 1, 1'b1, 4'd3, "press3");
    run_step(16'h0000, 3, 0, 1'b0, 4'd3, "release3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
